mem_access_unit: RTL and testbench

Load/store initiator for the MEM stage. Accepts one load or store request from the pipeline, drives the data memory's address/writeData/memRead/memWrite interface, and returns a sign- or zero-extended load result or a store completion. The data memory is doubleword-indexed with one-cycle registered read latency, so the unit performs read-modify-write for sub-doubleword stores.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with read-modify-write for partial stores
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned requests instead of force-aligning them)
module mem_access_unit #(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic [63:0]       mem_address,
   output logic [63:0]       mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [63:0]       mem_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_DATA,
      WR_ISSUE,
      RESP
   } state_t;

   state_t      state;
   logic [1:0]  sizeQ;
   logic        unsQ;
   logic        storeQ;
   logic [63:0] wdataQ;
   logic [2:0]  offQ;

   logic [2:0]  alignMask;
   logic [2:0]  reqOff;
   logic [5:0]  laneShift;
   logic [63:0] shifted;
   logic [63:0] sizeMask;
   logic [63:0] laneMask;
   logic [63:0] loadExt;
   logic [63:0] merged;

   // Ready is decoded from state and suppressed while reset is held
   assign req_ready = (state == IDLE) && !reset;

   // Offset bits that must be zero for a naturally aligned access of the requested size
   always_comb begin
      case (req_size)
         2'b00:   alignMask = 3'b111;
         2'b01:   alignMask = 3'b110;
         2'b10:   alignMask = 3'b100;
         default: alignMask = 3'b000;
      endcase
      reqOff = req_addr[2:0] & alignMask;
   end

`ifdef MISALIGN_TRAP_EN
   logic misQ;
   logic reqMisaligned;
   assign reqMisaligned   = (req_addr[2:0] & ~alignMask) != 3'b000;
   assign resp_misaligned = misQ;
`else
   assign resp_misaligned = 1'b0;
`endif

   // Lane extraction for loads and little-endian lane merge for partial stores
   always_comb begin
      laneShift = {offQ, 3'b000};
      shifted   = mem_read_data >> laneShift;
      case (sizeQ)
         2'b00: begin
            sizeMask = 64'h0000_0000_0000_00FF;
            loadExt  = {{56{~unsQ & shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            sizeMask = 64'h0000_0000_0000_FFFF;
            loadExt  = {{48{~unsQ & shifted[15]}}, shifted[15:0]};
         end
         2'b10: begin
            sizeMask = 64'h0000_0000_FFFF_FFFF;
            loadExt  = {{32{~unsQ & shifted[31]}}, shifted[31:0]};
         end
         default: begin
            sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
            loadExt  = shifted;
         end
      endcase
      laneMask = sizeMask << laneShift;
      merged   = (mem_read_data & ~laneMask) | ((wdataQ & sizeMask) << laneShift);
   end

   // Access sequencer: every output is registered so strobes line up with state entry
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         sizeQ          <= 2'b00;
         unsQ           <= 1'b0;
         storeQ         <= 1'b0;
         wdataQ         <= 64'd0;
         offQ           <= 3'd0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= 64'd0;
         mem_write_data <= 64'd0;
         resp_valid     <= 1'b0;
         resp_rdata     <= 64'd0;
`ifdef MISALIGN_TRAP_EN
         misQ           <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  sizeQ       <= req_size;
                  unsQ        <= req_unsigned;
                  storeQ      <= req_store;
                  wdataQ      <= req_wdata;
                  offQ        <= reqOff;
                  mem_address <= 64'(req_addr[ADDR_W-1:3]);
`ifdef MISALIGN_TRAP_EN
                  if (reqMisaligned) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= 64'd0;
                     misQ       <= 1'b1;
                     state      <= RESP;
                  end else
`endif
                  if (req_store && (req_size == 2'b11)) begin
                     // Full doubleword store needs no merge, write straight away
                     mem_write      <= 1'b1;
                     mem_write_data <= req_wdata;
                     state          <= WR_ISSUE;
                  end else begin
                     mem_read <= 1'b1;
                     state    <= RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               mem_read <= 1'b0;
               state    <= RD_DATA;
            end
            RD_DATA: begin
               if (storeQ) begin
                  mem_write      <= 1'b1;
                  mem_write_data <= merged;
                  state          <= WR_ISSUE;
               end else begin
                  resp_valid <= 1'b1;
                  resp_rdata <= loadExt;
                  state      <= RESP;
               end
            end
            WR_ISSUE: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= 64'd0;
               state      <= RESP;
            end
            RESP: begin
               resp_valid  <= 1'b0;
               resp_rdata  <= 64'd0;
               mem_address <= 64'd0;
`ifdef MISALIGN_TRAP_EN
               misQ        <= 1'b0;
`endif
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench with cycle-scheduled reference model for mem_access_unit
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_misaligned;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_read_data;

   mem_access_unit #(.ADDR_W(64)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_store(req_store),
      .req_addr(req_addr),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned),
      .mem_address(mem_address),
      .mem_write_data(mem_write_data),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   int totalChecks = 0;
   int passChecks  = 0;
   int cyc = 0;
   bit monOn = 1'b0;
   bit memInit = 1'b1;

   // Data memory: doubleword array, one-cycle registered read
   logic [63:0] envMem [0:7];
   logic [63:0] rdReg;
   assign mem_read_data = rdReg;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (memInit) begin
         envMem[0] <= 64'h0123_4567_89AB_CDEF;
         envMem[1] <= 64'h1111_2222_3333_4444;
         envMem[2] <= 64'h8877_6655_4433_2211;
         envMem[3] <= 64'hF0E1_D2C3_B4A5_9687;
         envMem[4] <= 64'h0;
         envMem[5] <= 64'h0;
         envMem[6] <= 64'h0;
         envMem[7] <= 64'h0;
      end else begin
         if (mem_read)  rdReg <= envMem[mem_address[2:0]];
         if (mem_write) envMem[mem_address[2:0]] <= mem_write_data;
      end
   end

   // Reference model state and the expected per-cycle schedule
   logic [63:0] refMem [0:7];
   bit          expRd   [int];
   bit          expWr   [int];
   bit          expRsp  [int];
   logic [63:0] expAddr [int];
   logic [63:0] expWd   [int];
   logic [63:0] expRdat [int];
   bit          expMis  [int];

   logic [63:0] lastRdata;
   bit          lastMis;
   int          lastRespCyc = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalChecks++;
      if (act === exp) passChecks++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Cycle-by-cycle comparison against the schedule
   always @(negedge clk) begin
      if (monOn) begin
         check("mem_read", 64'(mem_read), 64'(expRd.exists(cyc)));
         check("mem_write", 64'(mem_write), 64'(expWr.exists(cyc)));
         check("resp_valid", 64'(resp_valid), 64'(expRsp.exists(cyc)));
         check("strobe_overlap", 64'(mem_read & mem_write), 64'd0);
         if (expWr.exists(cyc)) check("mem_write_data", mem_write_data, expWd[cyc]);
         if (expAddr.exists(cyc)) check("mem_address", mem_address, expAddr[cyc]);
         if (expRsp.exists(cyc)) begin
            check("resp_rdata", resp_rdata, expRdat[cyc]);
            check("resp_misaligned", 64'(resp_misaligned), 64'(expMis[cyc]));
         end
         if (resp_valid) begin
            lastRdata   = resp_rdata;
            lastMis     = resp_misaligned;
            lastRespCyc = cyc;
         end
      end
   end

   // Present a request, wait for acceptance, and schedule what the spec says must follow
   task automatic doReq(input bit st, input logic [63:0] addr, input logic [1:0] sz,
                        input bit uns, input logic [63:0] wd, input bit complete, output int a);
      int n, off, idx, waitN;
      bit mis;
      logic [63:0] w, v;
      req_store = st; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
      req_valid = 1'b1;
      waitN = 0;
      while (!req_ready && waitN < 20) begin
         @(negedge clk);
         waitN++;
      end
      if (!req_ready) begin
         totalChecks++;
         $display("FAIL accept_timeout: req_ready never rose within 20 cycles (cycle %0d)", cyc);
         a = -100;
         return;
      end
      a   = cyc + 1;
      n   = 1 << sz;
      off = int'(addr[2:0]);
      idx = int'(addr >> 3);
      mis = (off % n) != 0;
`ifdef MISALIGN_TRAP_EN
      if (mis) begin
         expRsp[a] = 1; expRdat[a] = 64'd0; expMis[a] = 1;
         @(posedge clk); #1;
         return;
      end
`else
      off = off - (off % n);
`endif
      w = refMem[idx];
      if (!complete) begin
         expRd[a] = 1; expAddr[a] = 64'(idx);
      end else if (!st) begin
         v = 64'd0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
         if (!uns && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
         expRd[a] = 1; expAddr[a] = 64'(idx);
         expRsp[a+2] = 1; expRdat[a+2] = v; expMis[a+2] = 0;
      end else if (n == 8) begin
         expWr[a] = 1; expAddr[a] = 64'(idx); expWd[a] = wd;
         expRsp[a+1] = 1; expRdat[a+1] = 64'd0; expMis[a+1] = 0;
         refMem[idx] = wd;
      end else begin
         v = w;
         for (int i = 0; i < n; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
         expRd[a] = 1; expAddr[a] = 64'(idx);
         expWr[a+2] = 1; expAddr[a+2] = 64'(idx); expWd[a+2] = v;
         expRsp[a+3] = 1; expRdat[a+3] = 64'd0; expMis[a+3] = 0;
         refMem[idx] = v;
      end
      @(posedge clk); #1;
   endtask

   task automatic idleFor(input int n);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   int a, a2;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = 64'd0;
      req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 64'd0;
      refMem[0] = 64'h0123_4567_89AB_CDEF;
      refMem[1] = 64'h1111_2222_3333_4444;
      refMem[2] = 64'h8877_6655_4433_2211;
      refMem[3] = 64'hF0E1_D2C3_B4A5_9687;
      for (int i = 4; i < 8; i++) refMem[i] = 64'h0;
      repeat (3) @(posedge clk);
      memInit = 1'b0;
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_mem_read", 64'(mem_read), 64'd0);
      check("reset_mem_write", 64'(mem_write), 64'd0);
      check("reset_resp_valid", 64'(resp_valid), 64'd0);
      check("reset_resp_mis", 64'(resp_misaligned), 64'd0);
      check("reset_mem_address", mem_address, 64'd0);
      check("reset_mem_wdata", mem_write_data, 64'd0);
      check("reset_resp_rdata", resp_rdata, 64'd0);
      reset = 1'b0;
      monOn = 1'b1;
      @(negedge clk);
      check("idle_req_ready", 64'(req_ready), 64'd1);

      // Byte loads from lane 7 of index 2
      doReq(1'b0, 64'h17, 2'b00, 1'b0, 64'd0, 1'b1, a);
      idleFor(5);
      check("ld_b_signed", lastRdata, 64'hFFFF_FFFF_FFFF_FF88);
      check("ld_b_latency", 64'(lastRespCyc), 64'(a + 2));
      doReq(1'b0, 64'h17, 2'b00, 1'b1, 64'd0, 1'b1, a);
      idleFor(5);
      check("ld_b_unsigned", lastRdata, 64'h0000_0000_0000_0088);

      // Doubleword store
      doReq(1'b1, 64'h20, 2'b11, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, a);
      idleFor(5);
      check("st_d_mem", envMem[4], 64'hDEAD_BEEF_CAFE_F00D);
      check("st_d_latency", 64'(lastRespCyc), 64'(a + 1));

      // Half store into lanes 2..3 of index 2
      doReq(1'b1, 64'h12, 2'b01, 1'b0, 64'h0000_0000_0000_ABCD, 1'b1, a);
      idleFor(6);
      check("st_h_mem", envMem[2], 64'h8877_6655_ABCD_2211);
      check("st_h_latency", 64'(lastRespCyc), 64'(a + 3));

      // Misaligned word load
      doReq(1'b0, 64'h05, 2'b10, 1'b0, 64'd0, 1'b1, a);
      idleFor(5);
`ifdef MISALIGN_TRAP_EN
      check("ld_w_mis_flag", 64'(lastMis), 64'd1);
      check("ld_w_mis_rdata", lastRdata, 64'd0);
      check("ld_w_mis_latency", 64'(lastRespCyc), 64'(a));
`else
      check("ld_w_aligned", lastRdata, 64'h0000_0000_0123_4567);
      check("ld_w_latency", 64'(lastRespCyc), 64'(a + 2));
`endif

      // More patterns checked by the model alone
      doReq(1'b0, 64'h1C, 2'b10, 1'b0, 64'd0, 1'b1, a);
      idleFor(5);
      check("ld_w_signed", lastRdata, 64'hFFFF_FFFF_F0E1_D2C3);
      doReq(1'b1, 64'h1F, 2'b00, 1'b0, 64'h0000_0000_0000_005A, 1'b1, a);
      idleFor(6);
      doReq(1'b0, 64'h1E, 2'b01, 1'b1, 64'd0, 1'b1, a);
      idleFor(5);
      check("ld_h_after_b_store", lastRdata, 64'h0000_0000_0000_5AE1);
      doReq(1'b0, 64'h20, 2'b11, 1'b0, 64'd0, 1'b1, a);
      idleFor(5);

      // Reset while a partial store sits in RD_DATA
      doReq(1'b1, 64'h08, 2'b00, 1'b0, 64'h0000_0000_0000_0077, 1'b0, a);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_req_ready", 64'(req_ready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_ready_after", 64'(req_ready), 64'd1);
      repeat (5) @(negedge clk);
      check("rst_mid_mem_untouched", envMem[1], 64'h1111_2222_3333_4444);

      // Load then partial store with req_valid held throughout
      doReq(1'b0, 64'h10, 2'b11, 1'b0, 64'd0, 1'b1, a);
      doReq(1'b1, 64'h0C, 2'b10, 1'b0, 64'h0000_0000_1122_3344, 1'b1, a2);
      idleFor(6);
      check("b2b_accept_gap", 64'(a2 - a), 64'd4);
      check("b2b_mem", envMem[1], 64'h1122_3344_3333_4444);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
